// File: rtl/st_bus_arbiter.sv
// st_bus_arbiter: 68000-style BR/BG/BGACK bus-grant arbiter for N DMA-class masters.
// A grant is issued only while the CPU address strobe is high. All state moves on the
// 8 MHz enable. The arbiter recovers from a master that never acknowledges, and it
// leaves the CPU a short gap after each release.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin winner selection).
// When the macro is not defined, the lowest index wins.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | CPU owns the bus; requests sampled on clk_en while as_n is high
//  S_GRANT   | bg_n[owner] low; waiting for BGACK, withdrawal or timeout
//  S_OWNED   | owner holds BGACK; bg_n released; waiting for BGACK to rise
//  S_RELEASE | all bg_n high; CPU keeps the bus for CPU_GAP ticks
module st_bus_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int GRANT_TIMEOUT = 16,
  parameter int CPU_GAP       = 1,
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk32,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   as_n,
  input  logic [NUM_MASTERS-1:0] br_n,
  input  logic [NUM_MASTERS-1:0] bgack_n_i,
  output logic [NUM_MASTERS-1:0] bg_n,
  output logic                   bgack_n,
  output logic                   bus_free,
  output logic [OW-1:0]          owner,
  output logic                   owner_valid,
  output logic                   grant_timeout
);

  localparam int TMAX = (GRANT_TIMEOUT > CPU_GAP) ? GRANT_TIMEOUT : CPU_GAP;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] GT_LAST  = (GRANT_TIMEOUT > 0) ? TW'(GRANT_TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] GAP_LAST = TW'(CPU_GAP);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_OWNED, S_RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] bg_n_q, bg_n_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   gto_q, gto_d;
  logic                   req_any;
  logic [OW-1:0]          win;
  logic                   own_req;
  logic                   own_ack;
`ifdef ARB_ROUND_ROBIN_EN
  logic [OW-1:0]          rr_q, rr_d;
`endif

  // Winner selection; descending scan so the first match in search order is the last written.
  always_comb begin
    req_any = 1'b0;
    win     = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (!br_n[(int'(rr_q) + 1 + k) % NUM_MASTERS]) begin
        req_any = 1'b1;
        win     = OW'((int'(rr_q) + 1 + k) % NUM_MASTERS);
      end
`else
      if (!br_n[k]) begin
        req_any = 1'b1;
        win     = OW'(k);
      end
`endif
    end
  end

  // Request and acknowledge of the current owner only; the other masters' BGACK is ignored.
  always_comb begin
    own_req = 1'b0;
    own_ack = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == OW'(i)) begin
        own_req = ~br_n[i];
        own_ack = ~bgack_n_i[i];
      end
    end
  end

  // Next-state and next-output logic; nothing moves without clk_en.
  always_comb begin
    state_d = state_q;
    bg_n_d  = bg_n_q;
    owner_d = owner_q;
    timer_d = timer_q;
    gto_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (as_n && req_any) begin
            state_d = S_GRANT;
            owner_d = win;
            timer_d = '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (win == OW'(i)) bg_n_d[i] = 1'b0;
            end
          end
        end
        S_GRANT: begin
          // BGACK has priority over a timeout that expires on the same tick.
          if (own_ack) begin
            state_d = S_OWNED;
            bg_n_d  = '1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d    = owner_q;
`endif
          end else if (!own_req) begin
            state_d = S_IDLE;
            bg_n_d  = '1;
          end else if ((GRANT_TIMEOUT != 0) && (timer_q == GT_LAST)) begin
            state_d = S_RELEASE;
            bg_n_d  = '1;
            gto_d   = 1'b1;
            timer_d = '0;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_OWNED: begin
          if (!own_ack) begin
            state_d = S_RELEASE;
            timer_d = '0;
          end
        end
        S_RELEASE: begin
          if (timer_q == GAP_LAST) state_d = S_IDLE;
          else                     timer_d = timer_q + TW'(1);
        end
        default: begin
          state_d = S_IDLE;
          bg_n_d  = '1;
        end
      endcase
    end
  end

  // State register with synchronous reset that overrides clk_en.
  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= S_IDLE;
      bg_n_q  <= '1;
      owner_q <= '0;
      timer_q <= '0;
      gto_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      bg_n_q  <= bg_n_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      gto_q   <= gto_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign bg_n          = bg_n_q;
  assign owner         = owner_q;
  assign grant_timeout = gto_q;
  assign owner_valid   = (state_q == S_GRANT) || (state_q == S_OWNED);
  assign bgack_n       = &bgack_n_i;
  assign bus_free      = (&bg_n_q) & bgack_n;

endmodule

// File: tb/tb_st_bus_arbiter.sv
// Bench for st_bus_arbiter: N=2, GRANT_TIMEOUT=4, CPU_GAP=1, clk_en every 4th clk32.
module tb_st_bus_arbiter;

  logic       clk32 = 1'b0;
  logic       reset, clk_en, as_n;
  logic [1:0] br_n, bgack_n_i, bg_n;
  logic       bgack_n, bus_free, owner_valid, grant_timeout;
  logic [0:0] owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       as_n;
    logic [1:0] br;
    logic [1:0] ack;
    logic [1:0] bg;
    logic       ov;
    logic       own;
    logic       gto;
    logic       bf;
    logic       bk;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic WIN = 1'b1;
`else
  localparam logic WIN = 1'b0;
`endif
  localparam logic [1:0] WIN_BG  = WIN ? 2'b01 : 2'b10;
  localparam logic [1:0] WIN_ACK = WIN ? 2'b01 : 2'b10;

  st_bus_arbiter #(.NUM_MASTERS(2), .GRANT_TIMEOUT(4), .CPU_GAP(1)) dut (
    .clk32(clk32), .reset(reset), .clk_en(clk_en), .as_n(as_n),
    .br_n(br_n), .bgack_n_i(bgack_n_i), .bg_n(bg_n), .bgack_n(bgack_n),
    .bus_free(bus_free), .owner(owner), .owner_valid(owner_valid),
    .grant_timeout(grant_timeout)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic a, input logic [1:0] br, input logic [1:0] ack,
                     input logic [1:0] bg, input logic ov, input logic own, input logic gto,
                     input logic bf, input logic bk);
    vec_t v;
    v.rst = rst; v.as_n = a; v.br = br; v.ack = ack;
    v.bg = bg; v.ov = ov; v.own = own; v.gto = gto; v.bf = bf; v.bk = bk;
    vecs.push_back(v);
  endtask

  // One clk_en tick: drive, push the expectation, pop and compare after the enabled edge.
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    reset = v.rst; as_n = v.as_n; br_n = v.br; bgack_n_i = v.ack;
    sb.push_back(v);
    clk_en = 1'b1;
    @(posedge clk32); #1;
    clk_en = 1'b0;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard_empty", n), 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d bg_n", n), 8'(bg_n), 8'(e.bg));
      chk($sformatf("v%0d owner_valid", n), 8'(owner_valid), 8'(e.ov));
      chk($sformatf("v%0d owner", n), 8'(owner), 8'(e.own));
      chk($sformatf("v%0d grant_timeout", n), 8'(grant_timeout), 8'(e.gto));
      chk($sformatf("v%0d bus_free", n), 8'(bus_free), 8'(e.bf));
      chk($sformatf("v%0d bgack_n", n), 8'(bgack_n), 8'(e.bk));
    end
    @(posedge clk32); #1;
    chk($sformatf("v%0d grant_timeout_width", n), 8'(grant_timeout), 8'd0);
    repeat (2) @(posedge clk32);
    #1;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; as_n = 1'b1; br_n = 2'b11; bgack_n_i = 2'b11;
    repeat (2) @(posedge clk32);
    #1;

    //  rst as  br     ack      bg      ov own  gto bf bk
    add(1, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // reset state
    add(0, 1, 2'b10, 2'b11,   2'b10, 1, 0,   0, 0, 1);  // grant master 0
    add(0, 1, 2'b10, 2'b10,   2'b11, 1, 0,   0, 0, 0);  // BGACK -> OWNED
    add(0, 1, 2'b11, 2'b10,   2'b11, 1, 0,   0, 0, 0);  // br ignored in OWNED
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // release
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // gap tick
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // idle
    for (int i = 0; i < 5; i++)
      add(0, 0, 2'b10, 2'b11, 2'b11, 0, 0,   0, 1, 1);  // as_n low blocks grant
    add(0, 1, 2'b10, 2'b11,   2'b10, 1, 0,   0, 0, 1);  // as_n high -> grant
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // withdrawal, no pulse
    add(0, 1, 2'b01, 2'b11,   2'b01, 1, 1,   0, 0, 1);  // grant master 1
    for (int i = 0; i < 3; i++)
      add(0, 1, 2'b01, 2'b11, 2'b01, 1, 1,   0, 0, 1);  // waiting
    add(0, 1, 2'b01, 2'b11,   2'b11, 0, 1,   1, 1, 1);  // timeout on 4th tick
    add(0, 1, 2'b01, 2'b11,   2'b11, 0, 1,   0, 1, 1);  // cpu gap
    add(0, 1, 2'b01, 2'b11,   2'b11, 0, 1,   0, 1, 1);  // idle
    add(0, 1, 2'b01, 2'b11,   2'b01, 1, 1,   0, 0, 1);  // regrant after gap
    add(0, 1, 2'b01, 2'b01,   2'b11, 1, 1,   0, 0, 0);  // OWNED by 1
    add(0, 1, 2'b01, 2'b00,   2'b11, 1, 1,   0, 0, 0);  // non-owner BGACK
    add(0, 1, 2'b11, 2'b01,   2'b11, 1, 1,   0, 0, 0);  // still OWNED
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 1,   0, 1, 1);  // release, owner held
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 1,   0, 1, 1);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 1,   0, 1, 1);
    add(0, 1, 2'b00, 2'b11,   2'b10, 1, 0,   0, 0, 1);  // both request, 0 wins
    add(0, 1, 2'b00, 2'b10,   2'b11, 1, 0,   0, 0, 0);
    add(0, 1, 2'b00, 2'b11,   2'b11, 0, 0,   0, 1, 1);  // master 0 releases
    add(0, 1, 2'b00, 2'b11,   2'b11, 0, 0,   0, 1, 1);
    add(0, 1, 2'b00, 2'b11,   2'b11, 0, 0,   0, 1, 1);
    add(0, 1, 2'b00, 2'b11,   WIN_BG, 1, WIN, 0, 0, 1); // fixed: 0, round-robin: 1
    add(0, 1, 2'b00, WIN_ACK, 2'b11, 1, WIN, 0, 0, 0);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, WIN, 0, 1, 1);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, WIN, 0, 1, 1);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, WIN, 0, 1, 1);
    add(0, 1, 2'b10, 2'b11,   2'b10, 1, 0,   0, 0, 1);  // grant master 0
    add(0, 1, 2'b10, 2'b01,   2'b10, 1, 0,   0, 0, 0);  // non-owner BGACK in GRANT
    add(0, 1, 2'b10, 2'b11,   2'b10, 1, 0,   0, 0, 1);
    add(0, 1, 2'b10, 2'b11,   2'b10, 1, 0,   0, 0, 1);
    add(0, 1, 2'b10, 2'b10,   2'b11, 1, 0,   0, 0, 0);  // BGACK beats timeout
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);
    add(0, 1, 2'b11, 2'b11,   2'b11, 0, 0,   0, 1, 1);
    add(0, 1, 2'b01, 2'b11,   2'b01, 1, 1,   0, 0, 1);  // grant master 1 before reset test

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset while in GRANT with clk_en low: cleared on the next clk32 edge.
    reset = 1'b1;
    @(posedge clk32); #1;
    chk("rst_in_grant bg_n", 8'(bg_n), 8'h3);
    chk("rst_in_grant owner_valid", 8'(owner_valid), 8'd0);
    chk("rst_in_grant owner", 8'(owner), 8'd0);
    reset = 1'b0;

    // Without clk_en nothing moves, even with a pending request.
    as_n = 1'b1; br_n = 2'b10; bgack_n_i = 2'b11;
    repeat (8) @(posedge clk32);
    #1;
    chk("no_clk_en bg_n", 8'(bg_n), 8'h3);
    clk_en = 1'b1;
    @(posedge clk32); #1;
    clk_en = 1'b0;
    chk("clk_en_grant bg_n", 8'(bg_n), 8'h2);
    chk("clk_en_grant owner_valid", 8'(owner_valid), 8'd1);

    // Short non-owner BGACK pulse mid-tick: visible combinationally, state unchanged.
    bgack_n_i = 2'b01;
    #1;
    chk("pulse bgack_n", 8'(bgack_n), 8'd0);
    chk("pulse bus_free", 8'(bus_free), 8'd0);
    @(posedge clk32); #1;
    bgack_n_i = 2'b11;
    #1;
    chk("pulse after bgack_n", 8'(bgack_n), 8'd1);
    chk("pulse after bg_n", 8'(bg_n), 8'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
